btb_assoc: RTL and testbench
============================

# btb_assoc

Parametrised, synthesizable N-way set-associative branch target buffer that replaces the per-field DPI-C BTB accessors used in simulation. It sits beside the fetch stage: a lookup port returns hit/target one cycle after the PC is presented, and an update port from branch resolution installs or refreshes entries. It adds what the flat BTB lacks: tag-matched associativity, per-set round-robin replacement, a sequenced full flush, and optional hit/miss counters.

## Interface
Parameters:
- PC_W, 32, PC and address width
- SETS, 64, number of sets; power of two, ≥2; IDX_W = log2(SETS)
- WAYS, 2, ways per set; power of two, 1..8
- TAG_W, 8, stored tag bits; requires IDX_W+2+TAG_W ≤ PC_W
- BTA_W, 32, stored target width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  lookup request
- req_pc  in  PC_W  lookup PC
- resp_valid  out  1  lookup response valid
- resp_hit  out  1  lookup hit
- resp_bta  out  BTA_W  predicted target; 0 on miss
- upd_valid  in  1  update request
- upd_pc  in  PC_W  branch PC
- upd_bta  in  BTA_W  resolved target
- upd_ready  out  1  update accepted when high (low during flush)
- flush_req  in  1  start invalidation of all entries
- busy  out  1  flush in progress
- hit_cnt  out  32  hits (only with BTB_PERF_CNT_EN)
- miss_cnt  out  32  misses (only with BTB_PERF_CNT_EN)

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[IDX_W+1+TAG_W:IDX_W+2]. Per entry: V, tag, BTA. Storage in flops; V bits and round-robin pointers are reset.
- Lookup: hit when any way in the set has V=1 and a matching tag; multiple matches → lowest way wins. resp_bta = that way's BTA, else 0.
- Update (upd_valid && upd_ready): tag match in set → overwrite BTA of matching way, pointer unchanged. Otherwise allocate the lowest invalid way; if none, the victim is the set's round-robin pointer, which then advances by 1 mod WAYS. The written entry gets V=1.
- FSM states IDLE, FLUSH. IDLE→FLUSH on flush_req; set counter = 0. In FLUSH: clear V of all ways and the pointer of set[counter], counter+1 each cycle; after set SETS-1 → IDLE. flush_req in FLUSH is ignored.
- During FLUSH: upd_ready=0 and updates are dropped; lookups still respond, with resp_hit=0.
- Reset mid-flush: state returns to IDLE immediately and all V bits clear.

## Timing
- Reset values: resp_valid=0, resp_hit=0, resp_bta=0, upd_ready=1, busy=0, counters=0, all V=0, all pointers=0.
- Lookup latency 1: response registered at the edge after req_valid; resp_valid is a 1-cycle pulse per request. Back-to-back requests give back-to-back responses.
- An update at edge N is visible to a lookup presented in cycle N+1. Same-cycle lookup and update to the same set: the lookup sees the pre-update contents.
- Flush: busy high for exactly SETS cycles, starting the cycle after flush_req is sampled. upd_ready = !busy.
- flush_req and upd_valid in the same IDLE cycle: the update is accepted and written, then the flush clears it.

## Configuration
- BTB_PERF_CNT_EN defined: hit_cnt and miss_cnt increment on each resp_valid (hit or miss). Lookups during FLUSH count as misses. Counters saturate at 0xFFFF_FFFF, are cleared only by reset, and are not cleared by flush.
- BTB_PERF_CNT_EN undefined: the counter ports and logic are absent.

## Structure
- Shared package btb_pkg: FSM state enum {IDLE, FLUSH}; the IDX_W/tag slicing functions; the entry struct {V, tag, BTA} typedef, parametrised through its users.
- One sub-module, btb_way_sel: combinational. Takes per-way V and tag-match vectors plus the round-robin pointer; outputs the hit way, the write way, and a pointer-advance flag. It is shared by the lookup and update paths.

## Test plan
- Reset, then lookup 0x8000_0000 → resp_valid 1 cycle later, hit=0, bta=0.
- Update pc=0x8000_0010, bta=0x8000_0100; lookup the same PC next cycle → hit=1, bta=0x8000_0100. Lookup a PC with the same index and a different tag → miss.
- WAYS=2: three updates with distinct tags to one set → third evicts way 0; the first PC misses, the second and third hit. The pointer advances to 1.
- Same-cycle update and lookup of one new PC → lookup misses; a repeat lookup next cycle hits.
- Fill entries, pulse flush_req → busy high for exactly SETS (64) cycles, upd_ready=0, an update issued mid-flush is dropped; afterwards all lookups miss. Assert rst mid-flush → busy=0 immediately.
- With BTB_PERF_CNT_EN: 3 hits and 2 misses → hit_cnt=3, miss_cnt=2; after a flush the counts are unchanged.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared definitions for the set-associative branch target buffer.
// Entry layout {V, tag, BTA} is declared by each user so it follows that user's widths.
package btb_pkg;

    // Flush sequencer states
    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } btb_state_e;

    // Word-aligned PC with the byte offset removed; callers truncate to IDX_W
    function automatic logic [63:0] pc_index(input logic [63:0] pc);
        return pc >> 2;
    endfunction

    // PC with offset and index removed; callers truncate to TAG_W
    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int unsigned idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/btb_way_sel.sv
// Way selection for one BTB set: hit way for lookups, victim way for updates.
// Purely combinational; used by both the lookup and the update path.
module btb_way_sel #(
    parameter int unsigned WAYS  = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [WAYS-1:0]  valid_i,
    input  logic [WAYS-1:0]  match_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic             hit_c,
    output logic [PTR_W-1:0] hit_way_c,
    output logic [PTR_W-1:0] wr_way_c,
    output logic             adv_c
);

    logic             free;
    logic [PTR_W-1:0] free_way;

    // Lowest valid matching way and lowest invalid way (descending scan keeps the lowest)
    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        free      = 1'b0;
        free_way  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_i[w] && match_i[w]) begin
                hit_c     = 1'b1;
                hit_way_c = PTR_W'(w);
            end
            if (!valid_i[w]) begin
                free     = 1'b1;
                free_way = PTR_W'(w);
            end
        end
    end

    // Write way: refresh a hit, else fill a hole, else evict the round-robin victim
    always_comb begin
        wr_way_c = ptr_i;
        adv_c    = 1'b0;
        if (hit_c) begin
            wr_way_c = hit_way_c;
        end else if (free) begin
            wr_way_c = free_way;
        end else begin
            wr_way_c = ptr_i;
            adv_c    = 1'b1;
        end
    end

endmodule

// File: rtl/btb_assoc.sv
// N-way set-associative branch target buffer with one-cycle lookup, update port,
// per-set round-robin replacement and a one-set-per-cycle flush sequencer.
// Optional hit/miss counters are built when BTB_PERF_CNT_EN is defined.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned SETS  = 64,
    parameter int unsigned WAYS  = 2,
    parameter int unsigned TAG_W = 8,
    parameter int unsigned BTA_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [PC_W-1:0]  req_pc,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [BTA_W-1:0] resp_bta,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic [BTA_W-1:0] upd_bta,
    output logic             upd_ready,
    input  logic             flush_req,
    output logic             busy
`ifdef BTB_PERF_CNT_EN
    ,
    output logic [31:0]      hit_cnt,
    output logic [31:0]      miss_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef struct packed {
        logic             v;
        logic [TAG_W-1:0] tag;
        logic [BTA_W-1:0] bta;
    } entry_t;

    btb_state_e                  state_q, state_d;
    logic [IDX_W-1:0]            cnt_q, cnt_d;
    entry_t [SETS-1:0][WAYS-1:0] ent_q, ent_d;
    logic [SETS-1:0][PTR_W-1:0]  ptr_q, ptr_d;
    logic                        resp_valid_q, resp_valid_d;
    logic                        resp_hit_q, resp_hit_d;
    logic [BTA_W-1:0]            resp_bta_q, resp_bta_d;
    logic                        upd_ready_q, upd_ready_d;
    logic                        busy_q, busy_d;

    logic [IDX_W-1:0]            lk_idx, up_idx;
    logic [TAG_W-1:0]            lk_tag, up_tag;
    logic [WAYS-1:0]             lk_valid, lk_match, up_valid, up_match;
    logic                        lk_hit;
    logic [PTR_W-1:0]            lk_way;
    logic [PTR_W-1:0]            lk_unused_wr_way;
    logic                        lk_unused_adv;
    logic                        up_unused_hit;
    logic [PTR_W-1:0]            up_unused_hit_way;
    logic [PTR_W-1:0]            up_wr_way;
    logic                        up_adv;
    logic                        upd_fire;

    assign lk_idx = IDX_W'(pc_index(64'(req_pc)));
    assign lk_tag = TAG_W'(pc_tag(64'(req_pc), IDX_W));
    assign up_idx = IDX_W'(pc_index(64'(upd_pc)));
    assign up_tag = TAG_W'(pc_tag(64'(upd_pc), IDX_W));

    // Per-way valid and tag-compare vectors for the addressed sets
    always_comb begin
        lk_valid = '0;
        lk_match = '0;
        up_valid = '0;
        up_match = '0;
        for (int w = 0; w < WAYS; w++) begin
            lk_valid[w] = ent_q[lk_idx][w].v;
            lk_match[w] = (ent_q[lk_idx][w].tag == lk_tag);
            up_valid[w] = ent_q[up_idx][w].v;
            up_match[w] = (ent_q[up_idx][w].tag == up_tag);
        end
    end

    btb_way_sel #(
        .WAYS  (WAYS),
        .PTR_W (PTR_W)
    ) u_lk_sel (
        .valid_i   (lk_valid),
        .match_i   (lk_match),
        .ptr_i     ('0),
        .hit_c     (lk_hit),
        .hit_way_c (lk_way),
        .wr_way_c  (lk_unused_wr_way),
        .adv_c     (lk_unused_adv)
    );

    btb_way_sel #(
        .WAYS  (WAYS),
        .PTR_W (PTR_W)
    ) u_up_sel (
        .valid_i   (up_valid),
        .match_i   (up_match),
        .ptr_i     (ptr_q[up_idx]),
        .hit_c     (up_unused_hit),
        .hit_way_c (up_unused_hit_way),
        .wr_way_c  (up_wr_way),
        .adv_c     (up_adv)
    );

    // Updates are only taken while the flush sequencer is idle
    assign upd_fire = upd_valid && (state_q == IDLE);

    // Next state: update writes, flush sequencing and the registered lookup response
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ent_d        = ent_q;
        ptr_d        = ptr_q;
        resp_valid_d = req_valid;
        resp_hit_d   = 1'b0;
        resp_bta_d   = '0;

        unique case (state_q)
            IDLE: begin
                if (upd_fire) begin
                    ent_d[up_idx][up_wr_way].v   = 1'b1;
                    ent_d[up_idx][up_wr_way].tag = up_tag;
                    ent_d[up_idx][up_wr_way].bta = upd_bta;
                    if (up_adv) begin
                        ptr_d[up_idx] = PTR_W'((32'(ptr_q[up_idx]) + 32'd1) % WAYS);
                    end
                end
                if (flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                for (int w = 0; w < WAYS; w++) begin
                    ent_d[cnt_q][w].v = 1'b0;
                end
                ptr_d[cnt_q] = '0;
                cnt_d        = cnt_q + IDX_W'(1);
                if (cnt_q == IDX_W'(SETS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Lookups read the pre-update contents and never hit while flushing
        if (req_valid && (state_q == IDLE) && lk_hit) begin
            resp_hit_d = 1'b1;
            resp_bta_d = ent_q[lk_idx][lk_way].bta;
        end

        busy_d      = (state_d == FLUSH);
        upd_ready_d = !busy_d;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ent_q        <= '0;
            ptr_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_bta_q   <= '0;
            upd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ent_q        <= ent_d;
            ptr_q        <= ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_bta_q   <= resp_bta_d;
            upd_ready_q  <= upd_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;
    assign resp_bta   = resp_bta_q;
    assign upd_ready  = upd_ready_q;
    assign busy       = busy_q;

`ifdef BTB_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Saturating counters advanced together with each registered response
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (resp_valid_d) begin
            if (resp_hit_d) begin
                if (hit_cnt_q != 32'hFFFF_FFFF) begin
                    hit_cnt_d = hit_cnt_q + 32'd1;
                end
            end else begin
                if (miss_cnt_q != 32'hFFFF_FFFF) begin
                    miss_cnt_d = miss_cnt_q + 32'd1;
                end
            end
        end
    end

    // Counter registers, cleared by reset only
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc against a behavioural set/way model.
// Counter checks are compiled in when BTB_PERF_CNT_EN is defined.
module tb_btb_assoc;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned SETS  = 64;
    localparam int unsigned WAYS  = 2;
    localparam int unsigned TAG_W = 8;
    localparam int unsigned BTA_W = 32;
    localparam int unsigned IDX_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic [PC_W-1:0]  req_pc;
    logic             resp_valid;
    logic             resp_hit;
    logic [BTA_W-1:0] resp_bta;
    logic             upd_valid;
    logic [PC_W-1:0]  upd_pc;
    logic [BTA_W-1:0] upd_bta;
    logic             upd_ready;
    logic             flush_req;
    logic             busy;
`ifdef BTB_PERF_CNT_EN
    logic [31:0]      hit_cnt;
    logic [31:0]      miss_cnt;
`endif

    btb_assoc #(
        .PC_W  (PC_W),
        .SETS  (SETS),
        .WAYS  (WAYS),
        .TAG_W (TAG_W),
        .BTA_W (BTA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_hit   (resp_hit),
        .resp_bta   (resp_bta),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_bta    (upd_bta),
        .upd_ready  (upd_ready),
        .flush_req  (flush_req),
        .busy       (busy)
`ifdef BTB_PERF_CNT_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model: per set a list of ways with valid/tag/target and a victim pointer
    bit          mv   [SETS][WAYS];
    int unsigned mtag [SETS][WAYS];
    logic [31:0] mbta [SETS][WAYS];
    int unsigned mptr [SETS];
    int unsigned exp_hits = 0;
    int unsigned exp_misses = 0;

    function automatic int unsigned f_idx(input logic [31:0] pc);
        return (pc / 4) % SETS;
    endfunction

    function automatic int unsigned f_tag(input logic [31:0] pc);
        return (pc / (4 * SETS)) % (1 << TAG_W);
    endfunction

    task automatic model_lookup(input logic [31:0] pc, output logic hit, output logic [31:0] bta);
        int unsigned s;
        s   = f_idx(pc);
        hit = 1'b0;
        bta = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (mv[s][w] && mtag[s][w] == f_tag(pc)) begin
                hit = 1'b1;
                bta = mbta[s][w];
            end
        end
    endtask

    task automatic model_update(input logic [31:0] pc, input logic [31:0] bta);
        int unsigned s;
        int          way;
        s   = f_idx(pc);
        way = -1;
        for (int w = 0; w < WAYS; w++)
            if (way < 0 && mv[s][w] && mtag[s][w] == f_tag(pc)) way = w;
        for (int w = 0; w < WAYS; w++)
            if (way < 0 && !mv[s][w]) way = w;
        if (way < 0) begin
            way     = int'(mptr[s]);
            mptr[s] = (mptr[s] + 1) % WAYS;
        end
        mv[s][way]   = 1'b1;
        mtag[s][way] = f_tag(pc);
        mbta[s][way] = bta;
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) begin
            mptr[s] = 0;
            for (int w = 0; w < WAYS; w++) mv[s][w] = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
`ifdef BTB_PERF_CNT_EN
        chk({tag, "_hit_cnt"}, 64'(hit_cnt), 64'(exp_hits));
        chk({tag, "_miss_cnt"}, 64'(miss_cnt), 64'(exp_misses));
`else
        if (tag.len() == 0) $display("empty counter tag");
`endif
    endtask

    // One lookup cycle checked against the model
    task automatic lookup_check(input string tag, input logic [31:0] pc);
        logic        eh;
        logic [31:0] eb;
        model_lookup(pc, eh, eb);
        req_valid = 1'b1;
        req_pc    = pc;
        step();
        req_valid = 1'b0;
        chk({tag, "_valid"}, 64'(resp_valid), 64'(1));
        chk({tag, "_hit"}, 64'(resp_hit), 64'(eh));
        chk({tag, "_bta"}, 64'(resp_bta), 64'(eb));
        if (eh) exp_hits++; else exp_misses++;
    endtask

    task automatic update(input logic [31:0] pc, input logic [31:0] bta);
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_bta   = bta;
        step();
        upd_valid = 1'b0;
        model_update(pc, bta);
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'h8000_0000 | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2);
    endfunction

    initial begin
        int unsigned nb;
        logic        eh;
        logic [31:0] eb;

        rst       = 1'b0;
        req_valid = 1'b0;
        req_pc    = '0;
        upd_valid = 1'b0;
        upd_pc    = '0;
        upd_bta   = '0;
        flush_req = 1'b0;
        model_clear();

        // Reset values
        step();
        step();
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_resp_hit", 64'(resp_hit), 64'(0));
        chk("rst_resp_bta", 64'(resp_bta), 64'(0));
        chk("rst_upd_ready", 64'(upd_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        check_counters("rst");
        rst = 1'b1;
        step();

        // Cold miss, then single-cycle response pulse
        lookup_check("cold", 32'h8000_0000);
        step();
        chk("pulse_end", 64'(resp_valid), 64'(0));

        // Install and hit; same index with another tag misses
        update(32'h8000_0010, 32'h8000_0100);
        lookup_check("hit1", 32'h8000_0010);
        chk("hit1_abs", 64'(resp_bta), 64'h8000_0100);
        lookup_check("alias", 32'h8000_0110);
        chk("alias_abs", 64'(resp_hit), 64'(0));

        // Round-robin eviction in one set
        update(32'h8000_0020, 32'h0000_1000);
        update(32'h8000_0120, 32'h0000_1100);
        update(32'h8000_0220, 32'h0000_1200);
        lookup_check("evict_a", 32'h8000_0020);
        chk("evict_a_abs", 64'(resp_hit), 64'(0));
        lookup_check("evict_b", 32'h8000_0120);
        lookup_check("evict_c", 32'h8000_0220);
        update(32'h8000_0320, 32'h0000_1300);
        lookup_check("ptr_adv_b", 32'h8000_0120);
        chk("ptr_adv_b_abs", 64'(resp_hit), 64'(0));
        lookup_check("ptr_adv_c", 32'h8000_0220);
        lookup_check("ptr_adv_d", 32'h8000_0320);
        update(32'h8000_0220, 32'h0000_2200);
        lookup_check("refresh", 32'h8000_0220);

        // Same-cycle update and lookup sees old contents
        model_lookup(32'h8000_0040, eh, eb);
        req_valid = 1'b1;
        req_pc    = 32'h8000_0040;
        upd_valid = 1'b1;
        upd_pc    = 32'h8000_0040;
        upd_bta   = 32'h0000_4040;
        step();
        req_valid = 1'b0;
        upd_valid = 1'b0;
        chk("same_cyc_hit", 64'(resp_hit), 64'(eh));
        chk("same_cyc_abs", 64'(resp_hit), 64'(0));
        exp_misses++;
        model_update(32'h8000_0040, 32'h0000_4040);
        lookup_check("same_cyc_next", 32'h8000_0040);

        // Random mixed traffic
        for (int c = 0; c < 300; c++) begin
            logic        rv;
            logic        uv;
            logic [31:0] rpc;
            logic [31:0] upc;
            logic [31:0] ub;
            rv  = 1'($urandom_range(0, 1));
            uv  = 1'($urandom_range(0, 1));
            rpc = rand_pc();
            upc = rand_pc();
            ub  = $urandom;
            model_lookup(rpc, eh, eb);
            req_valid = rv;
            req_pc    = rpc;
            upd_valid = uv;
            upd_pc    = upc;
            upd_bta   = ub;
            step();
            chk("rnd_valid", 64'(resp_valid), 64'(rv));
            if (rv) begin
                chk("rnd_hit", 64'(resp_hit), 64'(eh));
                chk("rnd_bta", 64'(resp_bta), 64'(eb));
                if (eh) exp_hits++; else exp_misses++;
            end
            if (uv) model_update(upc, ub);
        end
        req_valid = 1'b0;
        upd_valid = 1'b0;
        check_counters("rnd");

        // Flush with a same-cycle update, mid-flush lookup and dropped update
        update(32'h8000_0350, 32'h0000_5350);
        upd_valid = 1'b1;
        upd_pc    = 32'h8000_0354;
        upd_bta   = 32'h0000_5354;
        flush_req = 1'b1;
        step();
        upd_valid = 1'b0;
        flush_req = 1'b0;
        chk("flush_busy_start", 64'(busy), 64'(1));
        chk("flush_ready_start", 64'(upd_ready), 64'(0));
        nb = 0;
        while (busy === 1'b1 && nb < 200) begin
            nb++;
            if (nb == 10) begin
                req_valid = 1'b1;
                req_pc    = 32'h8000_0350;
                upd_valid = 1'b1;
                upd_pc    = 32'h8000_0008;
                upd_bta   = 32'h0000_0008;
                flush_req = 1'b1;
            end
            step();
            if (nb == 10) begin
                req_valid = 1'b0;
                upd_valid = 1'b0;
                flush_req = 1'b0;
                chk("mid_flush_valid", 64'(resp_valid), 64'(1));
                chk("mid_flush_hit", 64'(resp_hit), 64'(0));
                chk("mid_flush_bta", 64'(resp_bta), 64'(0));
                chk("mid_flush_ready", 64'(upd_ready), 64'(0));
                exp_misses++;
            end
        end
        chk("flush_len", 64'(nb), 64'(SETS));
        chk("flush_ready_end", 64'(upd_ready), 64'(1));
        model_clear();
        check_counters("post_flush");
        lookup_check("pf_a", 32'h8000_0350);
        lookup_check("pf_b", 32'h8000_0354);
        lookup_check("pf_c", 32'h8000_0008);
        lookup_check("pf_d", 32'h8000_0010);
        for (int i = 0; i < 8; i++) lookup_check("pf_rnd", rand_pc());

        // Reset in the middle of a flush
        update(32'h8000_0010, 32'h0000_0010);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        for (int i = 0; i < 2; i++) step();
        chk("pre_rst_busy", 64'(busy), 64'(1));
        rst = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_ready", 64'(upd_ready), 64'(1));
        step();
        rst = 1'b1;
        model_clear();
        exp_hits   = 0;
        exp_misses = 0;
        check_counters("rst_mid");

        // Three hits and two misses from a clean start, then a flush
        lookup_check("cnt_m1", 32'h8000_0010);
        update(32'h8000_0060, 32'h0000_6000);
        update(32'h8000_0064, 32'h0000_6400);
        update(32'h8000_0160, 32'h0000_6100);
        lookup_check("cnt_h1", 32'h8000_0060);
        lookup_check("cnt_h2", 32'h8000_0064);
        lookup_check("cnt_h3", 32'h8000_0160);
        lookup_check("cnt_m2", 32'h8000_0260);
`ifdef BTB_PERF_CNT_EN
        chk("cnt_hits3", 64'(hit_cnt), 64'(3));
        chk("cnt_miss2", 64'(miss_cnt), 64'(2));
`endif
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        nb = 0;
        while (busy === 1'b1 && nb < 200) begin
            nb++;
            step();
        end
        chk("flush2_len", 64'(nb), 64'(SETS));
        model_clear();
        check_counters("cnt_after_flush");
        lookup_check("cnt_pf", 32'h8000_0060);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
